// File: rtl/sram_like_bridge.sv
// sram_like_bridge: adapts a core-side SRAM port (level-held enable, byte
// enables) to an SRAM-like bus (req/addr_ok/data_ok handshakes). It serves
// either the instruction or the data side, holds the response while the
// pipeline is stalled, and drains accesses cancelled by a flush.
// Optional feature macro: BRIDGE_PERF_CNT_EN adds request/stall counters.
module sram_like_bridge #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int RDSZ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sram_en,
  input  logic [DW/8-1:0] sram_wen,
  input  logic [AW-1:0]   sram_addr,
  input  logic [DW-1:0]   sram_wdata,
  output logic [DW-1:0]   sram_rdata,
  output logic            stall,
  input  logic            flush,
  input  logic            longest_stall,
  output logic            busy,
  output logic            be_err,
  output logic            req,
  output logic            wr,
  output logic [1:0]      size,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   wdata,
  input  logic            addr_ok,
  input  logic            data_ok,
  input  logic [DW-1:0]   rdata
`ifdef BRIDGE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_req_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam int BW = DW / 8;
  localparam int OFFW = $clog2(BW);
  localparam logic [1:0] FULLSZ = 2'(OFFW);
  localparam logic [1:0] READSZ = 2'(RDSZ);
  localparam logic [AW-1:0] OFFMASK = AW'(BW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            drop_q, drop_d;
  logic            wr_q;
  logic [1:0]      size_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;

  logic [3:0]      beCnt;
  logic [OFFW-1:0] beLo;
  logic [BW-1:0]   beMask;
  logic [1:0]      beSize;
  logic            beAlignOk;
  logic            beLegal;

  logic            isWrite;
  logic [1:0]      issueSize;
  logic [AW-1:0]   issueAddr;
  logic            issueBeErr;
  logic            issue;
  logic            dropNow;
  logic            resp;
  logic            captureData;

  // Classify the byte-enable pattern: count, lowest lane, and whether it is a
  // naturally aligned contiguous run of 1/2/4/8 bytes.
  always_comb begin
    beCnt = '0;
    beLo = '0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (sram_wen[i]) beLo = OFFW'(i);
    end
    for (int i = 0; i < BW; i++) begin
      beCnt = beCnt + 4'(sram_wen[i]);
    end
    beMask = BW'((32'd1 << beCnt) - 32'd1) << beLo;
    beSize = '0;
    beAlignOk = 1'b0;
    case (beCnt)
      4'd1: begin beSize = 2'd0; beAlignOk = 1'b1; end
      4'd2: begin beSize = 2'd1; beAlignOk = (beLo[0] == 1'b0); end
      4'd4: begin beSize = 2'd2; beAlignOk = (beLo[1:0] == 2'b00); end
      4'd8: begin beSize = 2'd3; beAlignOk = (beLo == '0); end
      default: ;
    endcase
    beLegal = beAlignOk && (beMask == sram_wen);
  end

  // Translate the core request into bus size/address; illegal patterns fall
  // back to a full-width write so the bus never sees an odd size.
  always_comb begin
    isWrite = |sram_wen;
    issueSize = READSZ;
    issueAddr = sram_addr & ~OFFMASK;
    issueBeErr = 1'b0;
    if (isWrite) begin
      if (beLegal) begin
        issueSize = beSize;
        issueAddr = (sram_addr & ~OFFMASK) | AW'(beLo);
      end else begin
        issueSize = FULLSZ;
        issueBeErr = 1'b1;
      end
    end
  end

  // Drive the bus: combinationally from the core in the issue cycle, then from
  // the captured registers until the address is accepted.
  always_comb begin
    issue = (state_q == S_IDLE) && sram_en && !flush;
    req = 1'b0;
    wr = 1'b0;
    size = '0;
    addr = '0;
    wdata = '0;
    if (state_q == S_REQ) begin
      req = 1'b1;
      wr = wr_q;
      size = size_q;
      addr = addr_q;
      wdata = wdata_q;
    end else if (issue) begin
      req = 1'b1;
      wr = isWrite;
      size = issueSize;
      addr = issueAddr;
      wdata = sram_wdata;
    end
    be_err = issue && issueBeErr;
    busy = (state_q == S_REQ) || (state_q == S_WAIT);
    dropNow = drop_q || flush;
    resp = ((state_q == S_WAIT) && data_ok && !drop_q) || (state_q == S_HOLD);
    stall = sram_en && !resp && !flush;
    sram_rdata = ((state_q == S_WAIT) && data_ok) ? rdata : rdata_q;
    captureData = (state_q == S_WAIT) && data_ok && !dropNow;
  end

  // Next-state logic, including the drop flag that marks a cancelled access
  // still owed a data_ok by the bus.
  always_comb begin
    state_d = state_q;
    drop_d = drop_q;
    case (state_q)
      S_IDLE: begin
        if (issue) state_d = addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (flush) drop_d = 1'b1;
        if (addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_ok) begin
          drop_d = 1'b0;
          if (!dropNow && sram_en && longest_stall) state_d = S_HOLD;
          else state_d = S_IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        if (flush || !longest_stall) state_d = S_IDLE;
      end
    endcase
  end

  // State, issue-time request capture and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      drop_q <= 1'b0;
      wr_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q <= drop_d;
      if (issue) begin
        wr_q <= isWrite;
        size_q <= issueSize;
        addr_q <= issueAddr;
        wdata_q <= sram_wdata;
      end
      if (captureData) rdata_q <= rdata;
    end
  end

`ifdef BRIDGE_PERF_CNT_EN
  // Free-running counters of accepted requests and core stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_req_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req && addr_ok) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// Scoreboard bench for sram_like_bridge: stimulus pushes expected bus
// requests and core responses into queues, a monitor pops and compares them
// when the DUT raises a request or drops stall.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = '0;
  logic [31:0] sram_addr = '0;
  logic [31:0] sram_wdata = '0;
  logic [31:0] sram_rdata;
  logic        stall;
  logic        flush = 1'b0;
  logic        longest_stall = 1'b0;
  logic        busy;
  logic        be_err;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
`ifdef BRIDGE_PERF_CNT_EN
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        beErr;
  } ReqExp;

  ReqExp       reqQ[$];
  logic [31:0] respQ[$];
  int          checkCount = 0;
  int          passCount = 0;

  sram_like_bridge #(.DW(32), .AW(32), .RDSZ(2)) dut (
    .clk(clk), .rst(rst),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .stall(stall),
    .flush(flush), .longest_stall(longest_stall), .busy(busy), .be_err(be_err),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
`ifdef BRIDGE_PERF_CNT_EN
    , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checkCount++;
    $display("[TB] FAIL %s: event seen, none expected", name);
  endtask

  // One cycle: inputs change just after the rising edge, then wait to the
  // falling edge where outputs are sampled.
  task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] a,
                               input logic [31:0] wd, input logic aok, input logic dok,
                               input logic [31:0] rd, input logic fl, input logic ls);
    @(posedge clk);
    #1;
    sram_en = en; sram_wen = wen; sram_addr = a; sram_wdata = wd;
    addr_ok = aok; data_ok = dok; rdata = rd; flush = fl; longest_stall = ls;
    @(negedge clk);
  endtask

  task automatic pushRead(input logic [31:0] a);
    reqQ.push_back('{wr: 1'b0, size: 2'd2, addr: a, wdata: 32'h0, beErr: 1'b0});
  endtask

  // Monitor: checks each bus request while req is high and each core
  // response in the cycle stall falls.
  initial begin : monitor
    ReqExp       cur;
    logic        reqPrev;
    logic        stallPrev;
    logic [31:0] expData;
    cur = '0;
    reqPrev = 1'b0;
    stallPrev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        reqPrev = 1'b0;
        stallPrev = 1'b0;
      end else begin
        if (req) begin
          if (!reqPrev) begin
            if (reqQ.size() == 0) failNow("unexpected req");
            else begin
              cur = reqQ.pop_front();
              checkOutput("be_err at issue", be_err, cur.beErr);
            end
          end
          checkOutput("bus addr", addr, cur.addr);
          checkOutput("bus size", size, cur.size);
          checkOutput("bus wr", wr, cur.wr);
          if (cur.wr) checkOutput("bus wdata", wdata, cur.wdata);
        end
        if (sram_en && !flush && !stall && stallPrev) begin
          if (respQ.size() == 0) failNow("unexpected response");
          else begin
            expData = respQ.pop_front();
            checkOutput("sram_rdata at response", sram_rdata, expData);
          end
        end
        reqPrev = req;
        stallPrev = stall;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1, "[TB] timeout");
  end

  logic [3:0]  vecWen[8]   = '{4'b1100, 4'b0101, 4'b0001, 4'b1000, 4'b1111, 4'b0110, 4'b0011, 4'b0111};
  logic [31:0] vecAddr[8]  = '{32'h1000, 32'h2000, 32'h3001, 32'h3000, 32'h3002, 32'h4000, 32'h5000, 32'h6000};
  logic [1:0]  vecSize[8]  = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2};
  logic [31:0] vecExpA[8]  = '{32'h1002, 32'h2000, 32'h3000, 32'h3003, 32'h3000, 32'h4000, 32'h5000, 32'h6000};
  logic        vecErr[8]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin : stimulus
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] a;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset req", req, 0);
    checkOutput("reset wr", wr, 0);
    checkOutput("reset size", size, 0);
    checkOutput("reset addr", addr, 0);
    checkOutput("reset wdata", wdata, 0);
    checkOutput("reset sram_rdata", sram_rdata, 0);
    checkOutput("reset stall", stall, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset be_err", be_err, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic read: addr_ok one cycle after issue, data_ok one cycle later.
    pushRead(32'h104);
    respQ.push_back(32'hDEADBEEF);
    applyStimulus(1, 4'h0, 32'h107, 0, 0, 0, 0, 0, 0);
    checkOutput("read issue stall", stall, 1);
    checkOutput("read issue busy", busy, 0);
    applyStimulus(1, 4'h0, 32'h107, 0, 1, 0, 0, 0, 0);
    checkOutput("read req stall", stall, 1);
    checkOutput("read req busy", busy, 1);
    applyStimulus(1, 4'h0, 32'h107, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    checkOutput("read resp stall", stall, 0);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("read rdata held", sram_rdata, 32'hDEADBEEF);
    checkOutput("read busy done", busy, 0);

    // Writes with legal and illegal byte-enable patterns.
    for (int i = 0; i < 8; i++) begin
      wd = 32'hA0000000 | 32'(i);
      rd = 32'h000000F0 + 32'(i);
      reqQ.push_back('{wr: 1'b1, size: vecSize[i], addr: vecExpA[i], wdata: wd, beErr: vecErr[i]});
      respQ.push_back(rd);
      applyStimulus(1, vecWen[i], vecAddr[i], wd, 1, 0, 0, 0, 0);
      checkOutput("write issue stall", stall, 1);
      applyStimulus(1, vecWen[i], vecAddr[i], wd, 0, 1, rd, 0, 0);
      checkOutput("be_err after issue", be_err, 0);
      applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    end

    // Delayed addr_ok keeps request stable; longest_stall holds the response.
    pushRead(32'h400);
    respQ.push_back(32'h12345678);
    applyStimulus(1, 4'h0, 32'h400, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 4'h0, 32'h400, 0, 0, 0, 0, 0, 0);
      checkOutput("delayed req held", req, 1);
    end
    applyStimulus(1, 4'h0, 32'h400, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h400, 0, 0, 1, 32'h12345678, 0, 1);
    checkOutput("hold entry stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4'h0, 32'h400, 0, 0, 0, 32'hFFFFFFFF, 0, 1);
      checkOutput("hold sram_rdata", sram_rdata, 32'h12345678);
      checkOutput("hold stall", stall, 0);
      checkOutput("hold req", req, 0);
    end
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("hold release rdata", sram_rdata, 32'h12345678);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("after hold busy", busy, 0);

    // Flush in WAIT: late data_ok dropped, next read waits for the drain.
    pushRead(32'h500);
    applyStimulus(1, 4'h0, 32'h500, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h500, 0, 0, 0, 0, 1, 0);
    checkOutput("flush wait stall", stall, 0);
    checkOutput("flush wait busy", busy, 1);
    pushRead(32'h600);
    respQ.push_back(32'hCAFEF00D);
    applyStimulus(1, 4'h0, 32'h600, 0, 0, 0, 0, 0, 0);
    checkOutput("drain no req", req, 0);
    checkOutput("drain stall", stall, 1);
    applyStimulus(1, 4'h0, 32'h600, 0, 0, 1, 32'hBADBAD00, 0, 0);
    checkOutput("dropped data no req", req, 0);
    checkOutput("dropped data stall", stall, 1);
    checkOutput("dropped data busy", busy, 1);
    applyStimulus(1, 4'h0, 32'h600, 0, 1, 0, 0, 0, 0);
    checkOutput("after drain busy", busy, 0);
    checkOutput("rdata_q unchanged", sram_rdata, 32'h12345678);
    applyStimulus(1, 4'h0, 32'h600, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);

    // Flush together with data_ok: data discarded.
    pushRead(32'h700);
    applyStimulus(1, 4'h0, 32'h700, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h700, 0, 0, 1, 32'h0BADF00D, 1, 0);
    checkOutput("flush+data stall", stall, 0);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush+data busy", busy, 0);
    checkOutput("flush+data rdata", sram_rdata, 32'hCAFEF00D);

    // Flush in REQ: request is not withdrawn, its data is drained.
    pushRead(32'h800);
    applyStimulus(1, 4'h0, 32'h800, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4'h0, 32'h800, 0, 0, 0, 0, 1, 0);
    checkOutput("flush req held", req, 1);
    checkOutput("flush req busy", busy, 1);
    applyStimulus(0, 4'h0, 32'h0, 0, 1, 0, 0, 0, 0);
    checkOutput("flush req still high", req, 1);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 1, 32'h77777777, 0, 0);
    checkOutput("flush req drain busy", busy, 1);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush req done busy", busy, 0);
    checkOutput("flush req rdata", sram_rdata, 32'hCAFEF00D);

    // Flush in IDLE: nothing issued.
    applyStimulus(1, 4'h0, 32'h880, 0, 0, 0, 0, 1, 0);
    checkOutput("flush idle req", req, 0);
    checkOutput("flush idle stall", stall, 0);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    checkOutput("flush idle busy", busy, 0);

    // Flush in HOLD: back to IDLE, a new access issues immediately.
    pushRead(32'h900);
    respQ.push_back(32'h11112222);
    applyStimulus(1, 4'h0, 32'h900, 0, 1, 0, 0, 0, 1);
    applyStimulus(1, 4'h0, 32'h900, 0, 0, 1, 32'h11112222, 0, 1);
    applyStimulus(1, 4'h0, 32'h900, 0, 0, 0, 0, 1, 1);
    checkOutput("flush hold stall", stall, 0);
    pushRead(32'hA00);
    respQ.push_back(32'h33334444);
    applyStimulus(1, 4'h0, 32'hA00, 0, 1, 0, 0, 0, 1);
    checkOutput("after hold flush req", req, 1);
    checkOutput("after hold flush stall", stall, 1);
    applyStimulus(1, 4'h0, 32'hA00, 0, 0, 1, 32'h33334444, 0, 0);
    applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset in WAIT.
    pushRead(32'hB00);
    applyStimulus(1, 4'h0, 32'hB00, 0, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    sram_en = 1'b0; sram_addr = '0; addr_ok = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkOutput("mid reset req", req, 0);
    checkOutput("mid reset size", size, 0);
    checkOutput("mid reset addr", addr, 0);
    checkOutput("mid reset sram_rdata", sram_rdata, 0);
    checkOutput("mid reset stall", stall, 0);
    checkOutput("mid reset busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Ten reads with addr_ok one cycle late: two stall cycles each.
    for (int i = 0; i < 10; i++) begin
      a = 32'hC00 + 32'(4 * i);
      rd = 32'h5A5A0000 + 32'(i);
      pushRead(a);
      respQ.push_back(rd);
      applyStimulus(1, 4'h0, a, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 4'h0, a, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 4'h0, a, 0, 0, 1, rd, 0, 0);
      applyStimulus(0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    end
`ifdef BRIDGE_PERF_CNT_EN
    checkOutput("perf_req_cnt", perf_req_cnt, 10);
    checkOutput("perf_stall_cnt", perf_stall_cnt, 20);
`endif
    checkOutput("final sram_rdata", sram_rdata, 32'h5A5A0009);

    repeat (2) @(negedge clk);
    checkOutput("request queue drained", reqQ.size(), 0);
    checkOutput("response queue drained", respQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
